// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (16-bit word count followed by
// big-endian 32-bit words), writes each word into instruction memory and holds
// the core in reset until the whole image has been loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// that makes the 8-bit sum of every frame byte equal to zero.
module imem_loader #(
   parameter int unsigned        ADDR_W    = 6,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      StIdle, StLenHi, StLenLo, StData, StWrite, StDone, StErr, StChk
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t StFin = StChk;
`else
   localparam state_t StFin = StDone;
`endif

   // N may equal the full memory capacity, so the limit needs one extra bit.
   localparam logic [16:0] Cap = 17'd1 << ADDR_W;

   state_t            state, state_n;
   logic [7:0]        count_hi;
   logic [15:0]       count;
   logic [23:0]       word;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] word_idx;
   logic              accept;
   logic [16:0]       n_full;
   logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum;
   logic [7:0]        sum_n;
`endif

   assign accept    = in_valid & in_ready;
   assign n_full    = {1'b0, count_hi, in_byte};
   assign last_word = ({{(17 - ADDR_W){1'b0}}, word_idx} + 17'd1) == {1'b0, count};
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign sum_n     = sum + in_byte;
`endif

   // Next-state decode; outputs are all registered from this value.
   always_comb begin
      state_n = state;
      case (state)
         StIdle, StDone, StErr: if (start) state_n = StLenHi;
         StLenHi: if (accept) state_n = StLenLo;
         StLenLo: begin
            if (accept) begin
               if (n_full == 17'd0)  state_n = StFin;
               else if (n_full > Cap) state_n = StErr;
               else                   state_n = StData;
            end
         end
         StData:  if (accept && byte_idx == 2'd3) state_n = StWrite;
         StWrite: state_n = last_word ? StFin : StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
         StChk:   if (accept) state_n = (sum_n == 8'd0) ? StDone : StErr;
`endif
         default: state_n = StIdle;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         count_hi   <= '0;
         count      <= '0;
         word       <= '0;
         byte_idx   <= '0;
         word_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         state     <= state_n;
         in_ready  <= (state_n == StLenHi) || (state_n == StLenLo) ||
                      (state_n == StData)  || (state_n == StChk);
         imem_we   <= (state_n == StWrite);
         done      <= (state_n == StDone);
         error     <= (state_n == StErr);
         cpu_reset <= (state_n != StDone);

         if (accept) begin
            case (state)
               StLenHi: count_hi <= in_byte;
               StLenLo: begin
                  count    <= {count_hi, in_byte};
                  byte_idx <= '0;
                  word_idx <= '0;
               end
               StData: begin
                  word     <= {word[15:0], in_byte};
                  byte_idx <= byte_idx + 2'd1;
               end
               default: ;
            endcase
         end

         // Capture the write on the edge that accepts the 4th byte.
         if (state == StData && state_n == StWrite) begin
            imem_addr  <= BASE_ADDR + word_idx;
            imem_wdata <= {word, in_byte};
         end
         if (state == StWrite && state_n == StData) word_idx <= word_idx + 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
         // Start of a new frame clears the running sum; only accepted bytes add.
         if (state_n == StLenHi && state != StLenHi) sum <= '0;
         else if (accept)                             sum <= sum_n;
`endif
      end
   end

endmodule
